// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave whose SCLK/SS/MOSI are sampled into the clk
// domain. Every flop runs on posedge clk. A single-entry TX buffer feeds the
// transmit shift register at frame start, and completed receive words appear
// on DO with a one-clk DO_VALID pulse.
//
// Strobe semantics: DI_WE is a one-clk write strobe that is always accepted
// (there is no ready); DO_VALID and FE are one-clk pulses with no backpressure,
// so DO must be consumed in the cycle DO_VALID is high or read later while it
// holds.
module spi_slave_sync #(
    parameter int WIDTH     = 15,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             SCLK,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] DI,
    input  logic             DI_WE,
    output logic [WIDTH-1:0] DO,
    output logic             DO_VALID,
    output logic             TX_FULL,
    output logic             BUSY,
    output logic             UDR,
    output logic             FE
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Synchroniser chains: [0] and [1] are the two metastability stages,
    // [2] is the history stage used only for edge detection.
    logic [2:0] sclk_sr;
    logic [2:0] ss_sr;
    logic [1:0] mosi_sr;

    // Tracks how many SS stages hold real samples since clr was released, so
    // the preset value can never be mistaken for an SS that was high.
    logic [2:0] sync_vld;
    logic       armed;

    logic             sclk_rise, sclk_fall;
    logic             lead_edge, trail_edge;
    logic             sample_edge, shift_edge;
    logic             ss_fall, ss_rise;
    logic             mosi_s;

    logic [WIDTH-1:0] tx_buf;
    logic             tx_full;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] rx_next;
    logic [CW-1:0]    bit_cnt;
    logic             first_shift;
    logic [WIDTH-1:0] do_q;
    logic             do_valid_q;
    logic             udr_q;
    logic             fe_q;

    logic             start;
    logic             do_shift;
    logic             do_sample;
    logic             frame_done;
    logic             frame_err;

    // Bring the asynchronous SPI pins into the clk domain; SS presets high and
    // SCLK presets to its idle level so reset release creates no edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            sclk_sr <= {3{CPOL}};
            ss_sr   <= 3'b111;
            mosi_sr <= 2'b00;
        end else begin
            sclk_sr <= {sclk_sr[1:0], SCLK};
            ss_sr   <= {ss_sr[1:0], SS};
            mosi_sr <= {mosi_sr[0], MOSI};
        end
    end

    // Arm frame detection only once a genuine high SS has reached the edge stage.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_vld <= 3'b000;
            armed    <= 1'b0;
        end else begin
            sync_vld <= {sync_vld[1:0], 1'b1};
            if (sync_vld[2] && ss_sr[2]) begin
                armed <= 1'b1;
            end
        end
    end

    // Decode synchronised edges into sample/shift events for the chosen mode.
    always_comb begin
        sclk_rise   = sclk_sr[1] & ~sclk_sr[2];
        sclk_fall   = ~sclk_sr[1] & sclk_sr[2];
        lead_edge   = CPOL ? sclk_fall : sclk_rise;
        trail_edge  = CPOL ? sclk_rise : sclk_fall;
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        ss_fall     = ss_sr[2] & ~ss_sr[1];
        ss_rise     = ~ss_sr[2] & ss_sr[1];
        mosi_s      = mosi_sr[1];
    end

    // Next values of the shift registers for the configured bit order.
    always_comb begin
        tx_next = tx_sr;
        rx_next = rx_sr;
        if (MSB_FIRST) begin
            tx_next = {tx_sr[WIDTH-2:0], 1'b0};
            rx_next = {rx_sr[WIDTH-2:0], mosi_s};
        end else begin
            tx_next = {1'b0, tx_sr[WIDTH-1:1]};
            rx_next = {mosi_s, rx_sr[WIDTH-1:1]};
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: next state plus one-cycle datapath strobes.
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        do_shift   = 1'b0;
        do_sample  = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ss_fall && armed) begin
                    state_d = S_SHIFT;
                    start   = 1'b1;
                end
            end
            S_SHIFT: begin
                // The counter is always below WIDTH here, so an SS release
                // is by definition a short frame.
                if (ss_rise) begin
                    state_d   = S_IDLE;
                    frame_err = 1'b1;
                end else begin
                    do_shift = shift_edge;
                    if (sample_edge) begin
                        do_sample = 1'b1;
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            frame_done = 1'b1;
                            state_d    = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                // Extra SCLK edges are ignored until the master releases SS.
                if (ss_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // TX buffer, shift registers, bit counter and status flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            first_shift <= 1'b0;
            do_q        <= '0;
            do_valid_q  <= 1'b0;
            udr_q       <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            do_valid_q <= frame_done;
            fe_q       <= frame_err;
            if (start) begin
                bit_cnt     <= '0;
                rx_sr       <= '0;
                tx_full     <= 1'b0;
                // With CPHA=1 the first bit is already on MISO before the
                // first shift edge, so that edge must not advance the register.
                first_shift <= CPHA;
                if (DI_WE) begin
                    // A write racing the frame start goes straight out.
                    tx_sr <= DI;
                end else if (tx_full) begin
                    tx_sr <= tx_buf;
                end else begin
                    tx_sr <= '0;
                    udr_q <= 1'b1;
                end
            end else begin
                if (DI_WE) begin
                    tx_buf  <= DI;
                    tx_full <= 1'b1;
                end
                if (do_shift) begin
                    if (first_shift) begin
                        first_shift <= 1'b0;
                    end else begin
                        tx_sr <= tx_next;
                    end
                end
                if (do_sample) begin
                    rx_sr   <= rx_next;
                    bit_cnt <= bit_cnt + CW'(1);
                end
                if (frame_done) begin
                    do_q <= rx_next;
                end
            end
        end
    end

    // Output mapping; MISO only drives data while a frame is shifting.
    always_comb begin
        MISO     = (state_q == S_SHIFT) && (MSB_FIRST ? tx_sr[WIDTH-1] : tx_sr[0]);
        DO       = do_q;
        DO_VALID = do_valid_q;
        TX_FULL  = tx_full;
        BUSY     = (state_q != S_IDLE);
        UDR      = udr_q;
        FE       = fe_q;
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: drives two slaves (mode 0 / 15-bit / MSB first and
// mode 3 / 8-bit / LSB first) from a bit-banged SPI master. Received words are
// checked through a DO_VALID-driven expected queue; per-frame status comes
// from a vector table, with hand-written reset/abort sequences around it.
module tb_spi_slave_sync;

    localparam int WA   = 15;
    localparam int WB   = 8;
    localparam int HALF = 5;   // clk cycles per SCLK half period

    typedef struct {
        int          sel;
        logic        we;
        logic        we_at_start;
        logic [31:0] di;
        logic [31:0] mosi_word;
        int          nbits;
        logic        chk_miso;
        logic [31:0] exp_miso;
        logic [31:0] exp_do;
        int          exp_dv;
        int          exp_fe;
        logic        exp_udr;
    } vec_t;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          ss_a = 1'b1;
    logic          ss_b = 1'b1;
    logic [WA-1:0] di_a = '0;
    logic          di_we_a = 1'b0;
    logic [WB-1:0] di_b = '0;
    logic          di_we_b = 1'b0;

    logic          miso_a, do_valid_a, tx_full_a, busy_a, udr_a, fe_a;
    logic [WA-1:0] do_a;
    logic          miso_b, do_valid_b, tx_full_b, busy_b, udr_b, fe_b;
    logic [WB-1:0] do_b;

    int n_cmp = 0;
    int n_err = 0;
    int dv_cnt_a = 0;
    int dv_cnt_b = 0;
    int fe_cnt_a = 0;
    int fe_cnt_b = 0;
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    vec_t vecs[11];

    spi_slave_sync #(.WIDTH(WA), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .clr(clr), .SCLK(sclk), .SS(ss_a), .MOSI(mosi), .MISO(miso_a),
        .DI(di_a), .DI_WE(di_we_a), .DO(do_a), .DO_VALID(do_valid_a),
        .TX_FULL(tx_full_a), .BUSY(busy_a), .UDR(udr_a), .FE(fe_a)
    );

    spi_slave_sync #(.WIDTH(WB), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .clr(clr), .SCLK(sclk), .SS(ss_b), .MOSI(mosi), .MISO(miso_b),
        .DI(di_b), .DI_WE(di_we_b), .DO(do_b), .DO_VALID(do_valid_b),
        .TX_FULL(tx_full_b), .BUSY(busy_b), .UDR(udr_b), .FE(fe_b)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every DO_VALID pops the oldest expected word of its slave.
    always @(negedge clk) begin
        if (do_valid_a === 1'b1) begin
            dv_cnt_a++;
            if (exp_q_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL do_a_unexpected: got 0x%0h with no frame expected", do_a);
            end else begin
                check("do_a_scoreboard", 32'(do_a), exp_q_a.pop_front());
            end
        end
        if (do_valid_b === 1'b1) begin
            dv_cnt_b++;
            if (exp_q_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL do_b_unexpected: got 0x%0h with no frame expected", do_b);
            end else begin
                check("do_b_scoreboard", 32'(do_b), exp_q_b.pop_front());
            end
        end
        if (fe_a === 1'b1) fe_cnt_a++;
        if (fe_b === 1'b1) fe_cnt_b++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic get_miso(input int sel);
        return (sel == 0) ? miso_a : miso_b;
    endfunction
    function automatic logic [31:0] get_do(input int sel);
        return (sel == 0) ? 32'(do_a) : 32'(do_b);
    endfunction
    function automatic logic get_tx_full(input int sel);
        return (sel == 0) ? tx_full_a : tx_full_b;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic get_udr(input int sel);
        return (sel == 0) ? udr_a : udr_b;
    endfunction
    function automatic int get_dv(input int sel);
        return (sel == 0) ? dv_cnt_a : dv_cnt_b;
    endfunction
    function automatic int get_fe(input int sel);
        return (sel == 0) ? fe_cnt_a : fe_cnt_b;
    endfunction

    // Bit sent at position i of a frame; positions past the word send 1s.
    function automatic logic bit_of(input logic [31:0] word, input int i, input int w, input logic msb);
        if (i >= w) return 1'b1;
        return msb ? word[w-1-i] : word[i];
    endfunction

    task automatic set_ss(input int sel, input logic v);
        if (sel == 0) ss_a = v;
        else ss_b = v;
    endtask

    task automatic drive_we(input int sel, input logic [31:0] v, input logic en);
        if (sel == 0) begin
            di_a    = v[WA-1:0];
            di_we_a = en;
        end else begin
            di_b    = v[WB-1:0];
            di_we_b = en;
        end
    endtask

    task automatic write_di(input int sel, input logic [31:0] v);
        drive_we(sel, v, 1'b1);
        wait_clk(1);
        drive_we(sel, v, 1'b0);
    endtask

    // Bit-banged master for the selected slave; returns the MISO word seen.
    task automatic spi_frame(input int sel, input int nbits, input logic [31:0] word,
                             input logic we_at_start, input logic [31:0] di_start,
                             output logic [31:0] miso_word);
        int          w;
        int          idx;
        logic        cpha;
        logic        msb;
        logic [31:0] mask;
        w    = (sel == 0) ? WA : WB;
        cpha = (sel != 0);
        msb  = (sel == 0);
        mask = (32'd1 << w) - 32'd1;
        miso_word = '0;
        sclk = (sel != 0);
        wait_clk(4);
        if (nbits >= w) begin
            if (sel == 0) exp_q_a.push_back(word & mask);
            else exp_q_b.push_back(word & mask);
        end
        mosi = cpha ? 1'b0 : bit_of(word, 0, w, msb);
        set_ss(sel, 1'b0);
        if (we_at_start) begin
            // The SS fall is acted on at the third rising clk edge after it.
            wait_clk(2);
            drive_we(sel, di_start, 1'b1);
            wait_clk(1);
            drive_we(sel, di_start, 1'b0);
            wait_clk(3);
        end else begin
            wait_clk(6);
        end
        for (int i = 0; i < nbits; i++) begin
            idx = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                if (i < w) miso_word[idx] = get_miso(sel);
                sclk = ~sclk;
                wait_clk(HALF);
                sclk = ~sclk;
                mosi = bit_of(word, i + 1, w, msb);
                wait_clk(HALF);
            end else begin
                sclk = ~sclk;
                mosi = bit_of(word, i, w, msb);
                wait_clk(HALF);
                if (i < w) miso_word[idx] = get_miso(sel);
                sclk = ~sclk;
                wait_clk(HALF);
            end
        end
        wait_clk(2);
        set_ss(sel, 1'b1);
        wait_clk(8);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic [31:0] mw;
        int          dv0;
        int          fe0;
        dv0 = get_dv(v.sel);
        fe0 = get_fe(v.sel);
        if (v.we) begin
            write_di(v.sel, v.di);
            check($sformatf("v%0d_tx_full_after_write", k), 32'(get_tx_full(v.sel)), 32'd1);
        end
        spi_frame(v.sel, v.nbits, v.mosi_word, v.we_at_start, v.di, mw);
        if (v.chk_miso) check($sformatf("v%0d_miso_word", k), mw, v.exp_miso);
        check($sformatf("v%0d_do", k), get_do(v.sel), v.exp_do);
        check($sformatf("v%0d_do_valid_cycles", k), 32'(get_dv(v.sel) - dv0), 32'(v.exp_dv));
        check($sformatf("v%0d_fe_cycles", k), 32'(get_fe(v.sel) - fe0), 32'(v.exp_fe));
        check($sformatf("v%0d_udr", k), 32'(get_udr(v.sel)), 32'(v.exp_udr));
        check($sformatf("v%0d_tx_full_after_frame", k), 32'(get_tx_full(v.sel)), 32'd0);
        check($sformatf("v%0d_idle_busy_miso", k), {30'd0, get_busy(v.sel), get_miso(v.sel)}, 32'd0);
    endtask

    function automatic vec_t mk(input int sel, input logic we, input logic as, input logic [31:0] di,
                                input logic [31:0] mw, input int n, input logic chk,
                                input logic [31:0] em, input logic [31:0] edo,
                                input int dv, input int fe, input logic udr);
        vec_t v;
        v.sel = sel; v.we = we; v.we_at_start = as; v.di = di; v.mosi_word = mw;
        v.nbits = n; v.chk_miso = chk; v.exp_miso = em; v.exp_do = edo;
        v.exp_dv = dv; v.exp_fe = fe; v.exp_udr = udr;
        return v;
    endfunction

    initial begin
        logic [31:0] r_di_a, r_mo_a, r_di_b, r_mo_b;
        logic        busy_seen;
        int          dv0;
        int          fe0;

        r_di_a = 32'($urandom_range(0, 32767));
        r_mo_a = 32'($urandom_range(0, 32767));
        r_di_b = 32'($urandom_range(0, 255));
        r_mo_b = 32'($urandom_range(0, 255));
        //            sel we as  di         mosi      n  chk miso      do        dv fe udr
        vecs[0]  = mk(0, 1, 0, 32'h5A3C, 32'h1234, 15, 1, 32'h5A3C, 32'h1234, 1, 0, 0);
        vecs[1]  = mk(0, 1, 0, 32'h7FFF, 32'h4001, 15, 1, 32'h7FFF, 32'h4001, 1, 0, 0);
        vecs[2]  = mk(0, 1, 0, r_di_a,   r_mo_a,   15, 1, r_di_a,   r_mo_a,   1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 32'h0F0F, 32'h70F0, 15, 1, 32'h0F0F, 32'h70F0, 1, 0, 0);
        vecs[4]  = mk(0, 1, 0, 32'h2468, 32'h6CE3, 17, 1, 32'h2468, 32'h6CE3, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0000, 32'h0ABC, 15, 1, 32'h0000, 32'h0ABC, 1, 0, 1);
        vecs[6]  = mk(1, 0, 0, 32'h00,   32'hA5,    8, 1, 32'h00,   32'hA5,   1, 0, 1);
        vecs[7]  = mk(1, 1, 0, 32'h3C,   32'h5A,    8, 1, 32'h3C,   32'h5A,   1, 0, 1);
        vecs[8]  = mk(1, 1, 0, 32'h81,   32'h0F,    5, 0, 32'h00,   32'h5A,   0, 1, 1);
        vecs[9]  = mk(1, 1, 0, 32'hC3,   32'h96,    8, 1, 32'hC3,   32'h96,   1, 0, 1);
        vecs[10] = mk(1, 1, 0, r_di_b,   r_mo_b,    8, 1, r_di_b,   r_mo_b,   1, 0, 1);

        // Reset: outputs cleared while clr is held and after release.
        wait_clk(3);
        check("a_outputs_in_reset", 32'({do_a, do_valid_a, tx_full_a, busy_a, udr_a, fe_a, miso_a}), 32'd0);
        check("b_outputs_in_reset", 32'({do_b, do_valid_b, tx_full_b, busy_b, udr_b, fe_b, miso_b}), 32'd0);
        clr = 1'b0;
        wait_clk(6);
        check("a_outputs_after_release", 32'({do_a, do_valid_a, tx_full_a, busy_a, udr_a, fe_a, miso_a}), 32'd0);
        check("b_outputs_after_release", 32'({do_b, do_valid_b, tx_full_b, busy_b, udr_b, fe_b, miso_b}), 32'd0);

        for (int k = 0; k < 11; k++) begin
            run_vec(k, vecs[k]);
        end

        // clr in the middle of a frame, released while SS is still low.
        write_di(0, 32'h1111);
        sclk = 1'b0;
        mosi = 1'b1;
        ss_a = 1'b0;
        wait_clk(6);
        dv0 = dv_cnt_a;
        fe0 = fe_cnt_a;
        repeat (7) begin
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
        end
        check("clr_busy_mid_frame", 32'(busy_a), 32'd1);
        clr     = 1'b1;
        di_a    = 15'h7777;
        di_we_a = 1'b1;
        wait_clk(2);
        clr     = 1'b0;
        di_we_a = 1'b0;
        wait_clk(3);
        check("clr_a_outputs", 32'({do_a, do_valid_a, tx_full_a, busy_a, udr_a, fe_a, miso_a}), 32'd0);
        check("clr_b_outputs", 32'({do_b, do_valid_b, tx_full_b, busy_b, udr_b, fe_b, miso_b}), 32'd0);
        busy_seen = 1'b0;
        repeat (16) begin
            sclk = 1'b1;
            wait_clk(HALF);
            busy_seen = busy_seen | busy_a;
            sclk = 1'b0;
            wait_clk(HALF);
            busy_seen = busy_seen | busy_a;
        end
        check("clr_no_frame_while_ss_low", 32'(busy_seen), 32'd0);
        check("clr_no_do_valid", 32'(dv_cnt_a - dv0), 32'd0);
        check("clr_no_fe", 32'(fe_cnt_a - fe0), 32'd0);
        ss_a = 1'b1;
        wait_clk(10);
        run_vec(11, mk(0, 1, 0, 32'h3333, 32'h4CCC, 15, 1, 32'h3333, 32'h4CCC, 1, 0, 0));

        check("a_queue_drained", 32'(exp_q_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 Parameters SHALL be:
  WIDTH      15  frame length in bits, 2..32
  CPOL       0   SCLK idle level
  CPHA       0   0 = sample on leading edge, 1 = sample on trailing edge
  MSB_FIRST  1   1 = MSB shifted first on both MISO and MOSI
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk       in   1      system clock; every flop is clocked on its rising edge
  clr       in   1      reset, synchronous, active-high
  SCLK      in   1      SPI clock, asynchronous to clk
  SS        in   1      slave select, active-low, asynchronous
  MOSI      in   1      master data in, asynchronous
  MISO      out  1      slave data out
  DI        in   WIDTH  transmit word
  DI_WE     in   1      write strobe: DI is captured into the TX buffer
  DO        out  WIDTH  last complete received word
  DO_VALID  out  1      one-clk pulse when DO updates
  TX_FULL   out  1      TX buffer holds an unsent word
  BUSY      out  1      frame in progress (state != IDLE)
  UDR       out  1      sticky flag: a frame started while the TX buffer was empty
  FE        out  1      one-clk pulse: frame aborted before WIDTH bits

Function
REQ-003 SCLK, SS and MOSI SHALL each pass through a 2-flop synchroniser; edges SHALL be detected by comparing the 2nd and 3rd stages, so an input edge is acted on 3 clk after it occurs.
REQ-004 Correct operation SHALL be guaranteed for f_clk >= 8 x f_SCLK; MOSI setup to the sample edge SHALL be at least 2 clk.
REQ-005 Leading edge SHALL be SCLK rising when CPOL=0 and falling when CPOL=1; the sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the other edge SHALL be the shift edge.
REQ-006 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-007 IDLE -> SHIFT on synchronised SS falling: load the TX shift register from the TX buffer, clear TX_FULL, clear the bit counter.
REQ-008 If TX_FULL=0 at frame start, the shift register SHALL load all zeros and UDR SHALL set.
REQ-009 If DI_WE coincides with frame start, DI SHALL load directly into the shift register; TX_FULL SHALL stay 0 and UDR SHALL NOT set.
REQ-010 MISO SHALL present the current first-order bit (MSB or LSB per MSB_FIRST) of the shift register in SHIFT; MISO SHALL be 0 in IDLE and DONE.
REQ-011 On each shift edge in SHIFT the TX register SHALL advance one bit; when CPHA=1, the first shift edge of the frame SHALL NOT advance it.
REQ-012 On each sample edge in SHIFT, MOSI SHALL be shifted into the RX register per MSB_FIRST and the counter SHALL increment.
REQ-013 When the counter reaches WIDTH: DO <= RX word, DO_VALID=1 for exactly one clk, state -> DONE.
REQ-014 In DONE, SCLK edges SHALL be ignored; SS rising SHALL return the FSM to IDLE.
REQ-015 SS rising in SHIFT with counter < WIDTH: state -> IDLE, FE pulse for one clk, DO unchanged, no DO_VALID.
REQ-016 DI_WE in any state SHALL overwrite the TX buffer and set TX_FULL (last write wins).
REQ-017 BUSY SHALL equal (state != IDLE).

Reset
REQ-018 With clr=1 at a clk edge: state=IDLE; DO, RX/TX registers, TX buffer and counter = 0; TX_FULL=UDR=FE=DO_VALID=MISO=0.
REQ-019 Under clr the SS synchroniser SHALL preset to 1 and the SCLK synchroniser to CPOL, so no false edge is seen after release.
REQ-020 clr mid-frame SHALL abort the frame with no DO_VALID and no FE; a frame SHALL start only on an SS falling edge seen after clr is released.
REQ-021 clr SHALL take priority over DI_WE in the same cycle.

Verification
REQ-022 WIDTH=15, mode 0, MSB first: DI=0x5A3C written, then 15 SCLK from master sending 0x1234 -> MISO stream 0x5A3C; DO=0x1234; one DO_VALID; TX_FULL 1->0.
REQ-023 WIDTH=8, CPOL=1, CPHA=1, LSB first: master sends 0xA5 with TX buffer empty -> DO=0xA5, MISO all 0, UDR=1 until clr.
REQ-024 SS deasserted after 5 of 8 bits -> FE pulse, no DO_VALID, DO keeps its prior value; next full frame is received correctly.
REQ-025 17 SCLK cycles in one SS window with WIDTH=15 -> exactly one DO_VALID; extra edges do not alter DO.
REQ-026 clr asserted at bit 7 of 15, then released with SS still low -> no frame until SS goes high and falls again; all outputs at their reset values.
REQ-027 DI_WE=1 (DI=0x0F0F) in the same clk the SS fall is detected -> MISO sends 0x0F0F; UDR=0; TX_FULL=0.
